// File: rtl/led_seq_pkg.sv
// Shared types and widths for the LED sequencer: display modes, shift direction
// and datapath widths.
package led_seq_pkg;

  localparam int PRESC_W = 26;
  localparam int LED_W   = 8;

  typedef enum logic [1:0] {
    MODE_UP    = 2'd0,
    MODE_DOWN  = 2'd1,
    MODE_SHIFT = 2'd2,
    MODE_PAUSE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push button -> two-flop synchroniser -> stable-level debounce -> one-cycle
// press pulse on each accepted rising level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic switch,
  input  logic btn_in,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_prev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (switch) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      // Any sample that agrees with the accepted level restarts the stable count.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/led_sequencer_ctrl.sv
// 8-LED display controller: debounced mode/speed buttons, power-of-two step-rate
// prescaler and a mode FSM driving count-up, count-down, bounce-shift or pause.
module led_sequencer_ctrl
  import led_seq_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             switch,
  input  logic             btn_mode,
  input  logic             btn_speed,
  output logic [LED_W-1:0] led,
  output logic             tick,
  output logic [1:0]       mode,
  output logic [1:0]       speed
);

  logic               press_mode;
  logic               press_speed;
  logic [LED_W-1:0]   led_q;
  logic [LED_W-1:0]   led_step_d;
  logic               tick_q;
  mode_e              mode_q;
  logic [1:0]         speed_q;
  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] term;
  dir_e               dir_q;
  dir_e               dir_step_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk    (clk),
    .switch (switch),
    .btn_in (btn_mode),
    .press  (press_mode)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_speed_db (
    .clk    (clk),
    .switch (switch),
    .btn_in (btn_speed),
    .press  (press_speed)
  );

  assign term = PRESC_W'((CLK_HZ >> speed_q) - 1);

  // LED value and direction that a tick would produce in the current mode.
  always_comb begin
    led_step_d = led_q;
    dir_step_d = dir_q;
    case (mode_q)
      MODE_UP:   led_step_d = led_q + LED_W'(1);
      MODE_DOWN: led_step_d = led_q - LED_W'(1);
      MODE_SHIFT: begin
        if (dir_q == DIR_LEFT) begin
          led_step_d = led_q << 1;
          if (led_step_d == LED_W'(8'h80)) dir_step_d = DIR_RIGHT;
        end else begin
          led_step_d = led_q >> 1;
          if (led_step_d == LED_W'(8'h01)) dir_step_d = DIR_LEFT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (switch) begin
      led_q   <= '0;
      tick_q  <= 1'b0;
      mode_q  <= MODE_UP;
      speed_q <= 2'd0;
      cnt_q   <= '0;
      dir_q   <= DIR_LEFT;
    end else if (press_mode || press_speed) begin
      // A press restarts the rate period and suppresses any coincident step.
      cnt_q  <= '0;
      tick_q <= 1'b0;
      if (press_mode) begin
        mode_q <= next_mode(mode_q);
        if (next_mode(mode_q) == MODE_SHIFT) begin
          led_q <= LED_W'(8'h01);
          dir_q <= DIR_LEFT;
        end
      end
      if (press_speed) speed_q <= speed_q + 2'd1;
    end else if (mode_q == MODE_PAUSE) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == term) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
      led_q  <= led_step_d;
      dir_q  <= dir_step_d;
    end else begin
      cnt_q  <= cnt_q + PRESC_W'(1);
      tick_q <= 1'b0;
    end
  end

  assign led   = led_q;
  assign tick  = tick_q;
  assign mode  = mode_q;
  assign speed = speed_q;

endmodule

// File: tb/tb_led_sequencer_ctrl.sv
// Bench for led_sequencer_ctrl: a behavioural reference checked every cycle,
// plus directed scenarios with literal expectations.
module tb_led_sequencer_ctrl;

  localparam int CLK_HZ = 16;
  localparam int DEB    = 4;

  logic       clk = 1'b0;
  logic       switch = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_speed = 1'b0;
  logic [7:0] led;
  logic       tick;
  logic [1:0] mode;
  logic [1:0] speed;

  int n_cmp = 0;
  int n_bad = 0;

  led_sequencer_ctrl #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .switch    (switch),
    .btn_mode  (btn_mode),
    .btn_speed (btn_speed),
    .led       (led),
    .tick      (tick),
    .mode      (mode),
    .speed     (speed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a button level is accepted once the last DEB synchronised
  // samples all differ from the accepted level; the top sees the press two
  // edges after acceptance. Ticks are scheduled as absolute cycle numbers.
  logic [7:0] m_led;
  logic       m_tick;
  logic [1:0] m_mode;
  logic [1:0] m_speed;
  logic       m_dir;
  int         cyc = 0;
  int         next_tick = 0;
  bit         model_ok = 0;
  logic [7:0] hm, hs;
  logic       am, as, rm1, rm2, rs1, rs2;

  function automatic bit settled(input logic [7:0] h, input logic acc);
    for (int k = 2; k < DEB + 2; k++) if (h[k] == acc) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    logic pm, ps;
    cyc++;
    if (switch) begin
      hm = '0; hs = '0; am = 0; as = 0;
      rm1 = 0; rm2 = 0; rs1 = 0; rs2 = 0;
      m_led = 8'h00; m_tick = 0; m_mode = 2'd0; m_speed = 2'd0; m_dir = 0;
      next_tick = cyc + CLK_HZ;
      model_ok = 1;
    end else begin
      pm = rm2; ps = rs2;
      rm2 = rm1; rs2 = rs1;
      hm = {hm[6:0], btn_mode};
      hs = {hs[6:0], btn_speed};
      rm1 = 0; rs1 = 0;
      if (settled(hm, am)) begin am = ~am; rm1 = am; end
      if (settled(hs, as)) begin as = ~as; rs1 = as; end
      if (pm || ps) begin
        m_tick = 0;
        if (pm) begin
          m_mode = m_mode + 2'd1;
          if (m_mode == 2'd2) begin m_led = 8'h01; m_dir = 0; end
        end
        if (ps) m_speed = m_speed + 2'd1;
        next_tick = cyc + (CLK_HZ >> m_speed);
      end else if (m_mode == 2'd3) begin
        m_tick = 0;
        next_tick = cyc + (CLK_HZ >> m_speed);
      end else if (cyc == next_tick) begin
        m_tick = 1;
        next_tick = cyc + (CLK_HZ >> m_speed);
        case (m_mode)
          2'd0: m_led = m_led + 8'd1;
          2'd1: m_led = m_led - 8'd1;
          default: begin
            if (m_dir == 0) begin
              m_led = m_led << 1;
              if (m_led == 8'h80) m_dir = 1;
            end else begin
              m_led = m_led >> 1;
              if (m_led == 8'h01) m_dir = 0;
            end
          end
        endcase
      end else begin
        m_tick = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_led", led, m_led);
      check("model_tick", tick, m_tick);
      check("model_mode", mode, m_mode);
      check("model_speed", speed, m_speed);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit m, input bit s);
    btn_mode = m; btn_speed = s;
    step(10);
    btn_mode = 0; btn_speed = 0;
    step(10);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 200);
    if (!tick) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_tick: no tick within %0d cycles", n);
    end
  endtask

  initial begin
    int n, cnt;
    logic [7:0] prev, exp8;
    logic [7:0] shift_seq [15];
    int per [4];
    shift_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                  8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    per = '{8, 4, 2, 16};

    // 1: reset, UP count at speed 0, wrap FF->00
    step(2);
    check("rst_led", led, 8'h00);
    check("rst_tick", tick, 1'b0);
    check("rst_mode", mode, 2'd0);
    check("rst_speed", speed, 2'd0);
    switch = 0;
    for (int i = 1; i <= 4; i++) begin
      wait_tick(n);
      check("up_period", n, 16);
      check("up_led", led, i);
    end
    press(0, 1); press(0, 1); press(0, 1);
    check("speed3", speed, 2'd3);
    cnt = 0;
    while (led != 8'hFF && cnt < 3000) begin step(1); cnt++; end
    check("reach_ff", led, 8'hFF);
    wait_tick(n);
    check("up_wrap", led, 8'h00);
    press(0, 1);
    check("speed_wrap0", speed, 2'd0);

    // 2: bounced mode button, then held
    btn_mode = 1; step(1);
    btn_mode = 0; step(1);
    btn_mode = 1;
    n = 0;
    do begin step(1); n++; end while (mode == 2'd0 && n < 30);
    check("bounce_latency", n, 8);
    check("mode_down", mode, 2'd1);
    step(30);
    check("held_one_press", mode, 2'd1);
    btn_mode = 0; step(10);
    prev = led;
    wait_tick(n);
    exp8 = prev - 8'd1;
    check("down_step", led, exp8);

    // 3: SHIFT bounce sequence
    press(1, 0);
    check("mode_shift", mode, 2'd2);
    check("shift_load", led, 8'h01);
    for (int i = 0; i < 15; i++) begin
      wait_tick(n);
      check("shift_seq", led, shift_seq[i]);
    end

    // 4: speed sweep
    for (int i = 0; i < 4; i++) begin
      press(0, 1);
      check("speed_val", speed, (i + 1) % 4);
      wait_tick(n);
      wait_tick(n);
      check("speed_period", n, per[i]);
    end

    // 5: press coincident with terminal count, then simultaneous presses
    wait_tick(n);
    step(8);
    btn_speed = 1;
    step(8);
    check("coincide_no_tick", tick, 1'b0);
    check("coincide_speed", speed, 2'd1);
    btn_speed = 0;
    wait_tick(n);
    check("coincide_next", n, 8);
    step(4);
    press(1, 1);
    check("both_mode", mode, 2'd3);
    check("both_speed", speed, 2'd2);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin step(1); if (tick) cnt++; end
    check("pause_no_tick", cnt, 0);

    // 6: reset pulse mid-SHIFT at speed 2
    press(1, 0); press(1, 0); press(1, 0);
    check("pre_rst_mode", mode, 2'd2);
    check("pre_rst_speed", speed, 2'd2);
    step(7);
    switch = 1; step(1);
    check("rst2_led", led, 8'h00);
    check("rst2_mode", mode, 2'd0);
    check("rst2_speed", speed, 2'd0);
    check("rst2_tick", tick, 1'b0);
    switch = 0;
    step(40);
    check("rst2_no_press", mode, 2'd0);
    check("rst2_speed_hold", speed, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
